// File: rtl/tt_um_pwm_capture.sv
// PWM capture/decoder tile.
// Samples a PWM waveform on ui_in[0], measures high time and period in
// prescaled ticks, and presents the recovered 8-bit duty on uo_out.
// A constant-low or constant-high input times out and reads as 0 / 255.
//
// Ports:
//   clk      clock
//   rst_n    asynchronous reset, active-high (historical name)
//   ena      enable; low synchronously clears all state
//   ui_in    [0] PWM input (asynchronous), [7:1] unused
//   uo_out   latched duty (high ticks per period, saturated at 255)
//   uio_in   unused
//   uio_out  {meas_cnt[3:0], period_ok, level, timeout, valid}
//   uio_oe   constant 8'hFF
module tt_um_pwm_capture #(
    parameter int unsigned PRESCALE = 19,
    parameter int unsigned TIMEOUT  = 511
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned PCNT_W = (PRESCALE < 1) ? 1 : $clog2(PRESCALE + 1);
    localparam int unsigned PER_W  = 10;
    localparam int unsigned HI_W   = 9;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STUCK   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic               s1;
    logic               s2;
    logic               s3;
    logic [PCNT_W-1:0]  pcnt;
    logic [PER_W-1:0]   per_cnt;
    logic [PER_W-1:0]   per_nxt;
    logic [HI_W-1:0]    hi_cnt;
    logic [HI_W-1:0]    hi_nxt;
    logic [7:0]         duty;
    logic [7:0]         duty_nxt;
    logic               valid;
    logic               valid_nxt;
    logic               timeout;
    logic               timeout_nxt;
    logic               period_ok;
    logic               period_ok_nxt;
    logic [CNT_W-1:0]   meas_cnt;
    logic [CNT_W-1:0]   meas_cnt_nxt;

    logic               rise;
    logic               tick;
    logic [PER_W-1:0]   per_inc;
    logic [PER_W-1:0]   restart_val;
    logic               hit_timeout;
    logic               unused_inputs;

    assign unused_inputs = &{1'b0, ui_in[7:1], uio_in};

    assign rise = s2 & ~s3;
    assign tick = (pcnt == PCNT_W'(PRESCALE));

    // Saturating period increment; reaching TIMEOUT on a tick is the time-out event.
    assign per_inc     = (per_cnt != PER_W'(TIMEOUT)) ? per_cnt + PER_W'(1) : per_cnt;
    assign hit_timeout = tick && (per_inc == PER_W'(TIMEOUT));
    // A tick coinciding with the rise belongs to the new period.
    assign restart_val = tick ? PER_W'(1) : PER_W'(0);

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        per_nxt       = per_cnt;
        hi_nxt        = hi_cnt;
        duty_nxt      = duty;
        valid_nxt     = valid;
        timeout_nxt   = timeout;
        period_ok_nxt = period_ok;
        meas_cnt_nxt  = meas_cnt;

        case (state)
            IDLE: begin
                if (tick) begin
                    per_nxt = per_inc;
                end
                if (rise) begin
                    state_nxt = MEASURE;
                    per_nxt   = restart_val;
                    hi_nxt    = HI_W'(restart_val);
                end else if (hit_timeout) begin
                    state_nxt = STUCK;
                end
            end

            MEASURE: begin
                if (tick) begin
                    per_nxt = per_inc;
                    if (s2 && (hi_cnt != HI_W'(256))) begin
                        hi_nxt = hi_cnt + HI_W'(1);
                    end
                end
                if (rise) begin
                    duty_nxt      = hi_cnt[8] ? 8'hFF : hi_cnt[7:0];
                    period_ok_nxt = (per_cnt == PER_W'(256));
                    valid_nxt     = 1'b1;
                    timeout_nxt   = 1'b0;
                    meas_cnt_nxt  = meas_cnt + CNT_W'(1);
                    per_nxt       = restart_val;
                    hi_nxt        = HI_W'(restart_val);
                end else if (hit_timeout) begin
                    state_nxt = STUCK;
                end
            end

            STUCK: begin
                // On the leaving rise duty/timeout are held until the next latch.
                if (rise) begin
                    state_nxt = MEASURE;
                    per_nxt   = restart_val;
                    hi_nxt    = HI_W'(restart_val);
                end else begin
                    duty_nxt      = s2 ? 8'hFF : 8'h00;
                    timeout_nxt   = 1'b1;
                    valid_nxt     = 1'b1;
                    period_ok_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, synchronizer, prescaler and result registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= IDLE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            pcnt      <= '0;
            per_cnt   <= '0;
            hi_cnt    <= '0;
            duty      <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            period_ok <= 1'b0;
            meas_cnt  <= '0;
        end else if (!ena) begin
            state     <= IDLE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            pcnt      <= '0;
            per_cnt   <= '0;
            hi_cnt    <= '0;
            duty      <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            period_ok <= 1'b0;
            meas_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            s1        <= ui_in[0];
            s2        <= s1;
            s3        <= s2;
            pcnt      <= tick ? '0 : pcnt + PCNT_W'(1);
            per_cnt   <= per_nxt;
            hi_cnt    <= hi_nxt;
            duty      <= duty_nxt;
            valid     <= valid_nxt;
            timeout   <= timeout_nxt;
            period_ok <= period_ok_nxt;
            meas_cnt  <= meas_cnt_nxt;
        end
    end

    assign uo_out  = duty;
    assign uio_out = {meas_cnt, period_ok, s2, timeout, valid};
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_pwm_capture.sv
// Scoreboard bench for tt_um_pwm_capture: the stimulus process pushes the
// expected result of each completed PWM period (or time-out) into a queue,
// and a monitor pops and compares whenever the tile presents a new result.
module tb_tt_um_pwm_capture;

    typedef struct packed {
        logic [7:0] duty;
        logic       pok;
        logic       to;
        logic [3:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Chain model: a period's result is expected only when the next rise arrives.
    logic       have_prev = 1'b0;
    logic [7:0] prev_duty = 8'h00;
    logic       prev_pok = 1'b0;
    logic [3:0] exp_cnt = 4'd0;

    tt_um_pwm_capture dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic p, input logic t, input logic [3:0] c);
        exp_t e;
        e.duty = d;
        e.pok  = p;
        e.to   = t;
        e.cnt  = c;
        sb_q.push_back(e);
    endtask

    // One PWM period starting with a rise; assumes the caller is just after a negedge.
    task automatic period(input int hi, input int lo, input logic [7:0] d, input logic pok);
        if (have_prev) begin
            exp_cnt = exp_cnt + 4'd1;
            push(prev_duty, prev_pok, 1'b0, exp_cnt);
        end
        ui_in[0] = 1'b1;
        repeat (hi) @(negedge clk);
        ui_in[0] = 1'b0;
        repeat (lo) @(negedge clk);
        prev_duty = d;
        prev_pok  = pok;
        have_prev = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, sb_q.size(), 0);
    endtask

    // Monitor: a result is presented when the count changes, timeout rises,
    // or duty changes while timed out.
    initial begin
        logic [3:0] pc;
        logic       pt;
        logic [7:0] pd;
        exp_t       e;
        pc = 4'd0;
        pt = 1'b0;
        pd = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n || !ena) begin
                pc = 4'd0;
                pt = 1'b0;
                pd = 8'h00;
            end else begin
                if (uio_out[7:4] != pc || (uio_out[1] && !pt) || (uio_out[1] && uo_out != pd)) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_duty", int'(uo_out), int'(e.duty));
                        check("sb_period_ok", int'(uio_out[3]), int'(e.pok));
                        check("sb_timeout", int'(uio_out[1]), int'(e.to));
                        check("sb_valid", int'(uio_out[0]), 1);
                        check("sb_count", int'(uio_out[7:4]), int'(e.cnt));
                    end
                end
                pc = uio_out[7:4];
                pt = uio_out[1];
                pd = uo_out;
            end
        end
    end

    initial begin
        // Power-on reset.
        #2 rst_n = 1'b1;
        #2;
        check("reset_uo_out", int'(uo_out), 0);
        check("reset_uio_out", int'(uio_out), 0);
        check("reset_uio_oe", int'(uio_oe), 8'hFF);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;

        // Constant low after reset times out as duty 0.
        push(8'd0, 1'b0, 1'b1, 4'd0);
        wait_drain("timeout_low_latency", 511 * 20 + 40);

        // A rise leaves STUCK; constant high then times out as duty 255.
        ui_in[0] = 1'b1;
        push(8'd255, 1'b0, 1'b1, 4'd0);
        wait_drain("timeout_high_latency", 511 * 20 + 60);

        // Asynchronous reset mid-run clears outputs without a clock edge.
        @(posedge clk);
        #3 rst_n = 1'b1;
        ui_in[0] = 1'b0;
        #1;
        check("midrun_reset_uo_out", int'(uo_out), 0);
        check("midrun_reset_uio_out", int'(uio_out), 0);
        check("midrun_reset_uio_oe", int'(uio_oe), 8'hFF);
        @(negedge clk);
        rst_n = 1'b0;
        have_prev = 1'b0;
        exp_cnt = 4'd0;
        repeat (5) @(negedge clk);

        // Duty 64 at the nominal 256-tick period.
        repeat (3) period(1280, 3840, 8'd64, 1'b1);
        // Near-full and near-empty duty.
        period(5100, 20, 8'd255, 1'b1);
        period(20, 5100, 8'd1, 1'b1);
        // Off-spec periods: 300 ticks, then 400 ticks with 300 high (saturates).
        period(2000, 4000, 8'd100, 1'b0);
        period(6000, 2000, 8'd255, 1'b0);
        // Short periods to roll the measurement count through 15 -> 0.
        repeat (12) period(200, 200, 8'd10, 1'b0);
        wait_drain("chain_drain", 20);
        check("count_after_wrap", int'(uio_out[7:4]), int'(exp_cnt));

        // ena low for one clock mid-measurement clears everything.
        ena = 1'b0;
        @(negedge clk);
        check("ena_low_uo_out", int'(uo_out), 0);
        check("ena_low_uio_out", int'(uio_out), 0);
        ena = 1'b1;
        have_prev = 1'b0;
        exp_cnt = 4'd0;
        repeat (5) @(negedge clk);

        // First rise after resume yields no result.
        period(200, 200, 8'd10, 1'b0);
        check("resume_valid_after_first_rise", int'(uio_out[0]), 0);
        repeat (2) period(200, 200, 8'd10, 1'b0);
        wait_drain("resume_drain", 20);
        check("resume_valid_final", int'(uio_out[0]), 1);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
